pp_win_ctl: RTL and testbench
=============================

Name: pp_win_ctl

Overview:
- Sequencer that feeds the peak-to-peak detector. It collects ADC samples over a programmable window and tracks the max and min of each window.
- At the end of each window it presents rf_pp_top / rf_pp_btm, toggles rf_up_dn, and issues a widened pls strobe. The detector captures each window on the strobe's rising edge.
- Sits between the ADC sample stream and the detector. It also reports window completion, timeout, and overrun status to the register file.

Parameters:
- DW, 12, sample / peak width
- CW, 16, window-length and timeout counter width
- PLS_W, 4, pls high time in clk cycles (≥2 so the detector's two-flop edge detect sees it)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run enable
- rf_win_len  in  CW  valid samples per window; 0 treated as 1
- rf_win_tmo  in  CW  max clk cycles per window; 0 disables timeout
- adc_vld  in  1  sample strobe
- adc_dat  in  DW  unsigned sample
- rf_pp_top  out  DW  window maximum
- rf_pp_btm  out  DW  window minimum
- rf_up_dn  out  1  toggles once per completed window
- pls  out  1  capture strobe to detector
- win_done  out  1  one-cycle pulse when window results latch
- busy  out  1  high in any state except IDLE
- tmo_err  out  1  sticky; cleared by rst only
- ovr_err  out  1  sticky; sample arrived outside ACQ while en=1

Behaviour:
- Reset: state=IDLE. rf_pp_top=0, rf_pp_btm=0, rf_up_dn=0, pls=0, win_done=0, busy=0, tmo_err=0, ovr_err=0. Internal max=0, min=all-ones, counters=0.
- FSM states: IDLE, ACQ, LATCH, STROBE, GAP.
- IDLE → ACQ when en=1.
  - On ACQ entry: sample rf_win_len and rf_win_tmo into shadow registers. Mid-window register changes take effect at the next window.
  - On ACQ entry: max=0, min=all-ones, scnt=0, tcnt=0.
- ACQ:
  - Each adc_vld updates max/min with adc_dat (unsigned compare) and increments scnt. The first sample of a window therefore loads both max and min.
  - tcnt increments every cycle.
  - When adc_vld arrives with scnt == len-1, go to LATCH. That sample is included in the window.
  - If timeout is enabled and tcnt == tmo-1 with no completion, go to LATCH with tmo flag. Completion wins if both occur on the same cycle.
  - en=0 in ACQ: abort to IDLE next cycle, discarding partial results. Outputs hold their previous values.
- LATCH (1 cycle):
  - Normal: rf_pp_top<=max, rf_pp_btm<=min.
  - Timeout: rf_pp_top<=0, rf_pp_btm<=0, and set tmo_err.
  - In both cases: rf_up_dn<=~rf_up_dn, win_done=1. Go to STROBE.
  - Ordering guarantee: rf_up_dn and peaks change at least 1 cycle before pls rises.
- STROBE: pls=1 for exactly PLS_W cycles, then go to GAP.
- GAP: pls=0 for 2 cycles.
  - Then → ACQ if en=1, else → IDLE.
  - en=0 during LATCH, STROBE or GAP does not truncate the strobe.
- Latency: last sample accepted at cycle N → outputs and rf_up_dn valid at N+1, win_done at N+1, pls high N+2…N+1+PLS_W.
- Samples during LATCH, STROBE or GAP are dropped, and ovr_err is set if en=1.
- Minimum window period: len_samples + PLS_W + 3 cycles.
- pls is only ever a registered output; it never glitches.
- rst mid-operation: immediate return to reset values on the next clk, including during STROBE. pls drops.

Decomposition:
- Shared package pp_pkg:
  - DW and CW defaults
  - FSM state enum: IDLE=0, ACQ=1, LATCH=2, STROBE=3, GAP=4
  - constants PK_MIN_INIT = all-ones and PK_MAX_INIT = 0
- One natural sub-module: pp_minmax. It holds the max/min registers, with a clear input and a vld/dat update port, and is instantiated once.

Test Plan:
- win_len=4, tmo=0, samples 100,3000,50,2047 → rf_pp_top=3000, rf_pp_btm=50, rf_up_dn 0→1, win_done one cycle, pls high 4 cycles starting 1 cycle after win_done.
- win_len=0, single sample 1234 → treated as 1: top=btm=1234, one pls.
- win_len=8, tmo=20, only 3 samples → LATCH at tcnt=19: top=btm=0, tmo_err=1, pls still issued. Last sample landing on the timeout cycle with scnt==len-1 → normal latch, tmo_err stays 0.
- Three back-to-back windows (len=2: {10,20},{5,4095},{7,7}) → top/btm = 20/10, 4095/5, 7/7; rf_up_dn 1,0,1; adc_vld during STROBE → ovr_err=1.
- en dropped at 2nd sample of a len=4 window → IDLE, outputs unchanged, no pls. en dropped during STROBE → full PLS_W pulse, then IDLE.
- rst asserted in the 2nd cycle of STROBE → next cycle pls=0, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared widths, FSM encoding and peak-tracker init values for the peak-to-peak window sequencer.
package pp_pkg;

    localparam int unsigned PP_DW = 12;
    localparam int unsigned PP_CW = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACQ    = 3'd1,
        LATCH  = 3'd2,
        STROBE = 3'd3,
        GAP    = 3'd4
    } pp_state_e;

    localparam logic [PP_DW-1:0] PK_MIN_INIT = '1;
    localparam logic [PP_DW-1:0] PK_MAX_INIT = '0;

endpackage

// File: rtl/pp_minmax.sv
// Running max/min of the current window; also exposes the post-update values so the
// window's final sample can be latched in the same cycle it arrives.
module pp_minmax
    import pp_pkg::*;
#(
    parameter int unsigned DW = PP_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          upd_i,
    input  logic [DW-1:0] dat_i,
    output logic [DW-1:0] max_nxt_c,
    output logic [DW-1:0] min_nxt_c
);

    localparam logic [DW-1:0] MAX_INIT = '0;
    localparam logic [DW-1:0] MIN_INIT = '1;

    logic [DW-1:0] max_q;
    logic [DW-1:0] min_q;

    always_comb begin
        max_nxt_c = max_q;
        min_nxt_c = min_q;
        if (upd_i && (dat_i > max_q)) max_nxt_c = dat_i;
        if (upd_i && (dat_i < min_q)) min_nxt_c = dat_i;
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            max_q <= MAX_INIT;
            min_q <= MIN_INIT;
        end else begin
            max_q <= max_nxt_c;
            min_q <= min_nxt_c;
        end
    end

endmodule

// File: rtl/pp_win_ctl.sv
// Window sequencer for the peak-to-peak detector: acquires a window of samples, latches
// max/min, toggles rf_up_dn and issues a widened capture strobe.
module pp_win_ctl
    import pp_pkg::*;
#(
    parameter int unsigned DW    = PP_DW,
    parameter int unsigned CW    = PP_CW,
    parameter int unsigned PLS_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] rf_win_len,
    input  logic [CW-1:0] rf_win_tmo,
    input  logic          adc_vld,
    input  logic [DW-1:0] adc_dat,
    output logic [DW-1:0] rf_pp_top,
    output logic [DW-1:0] rf_pp_btm,
    output logic          rf_up_dn,
    output logic          pls,
    output logic          win_done,
    output logic          busy,
    output logic          tmo_err,
    output logic          ovr_err
);

    localparam int unsigned PW = $clog2(PLS_W + 1);

    pp_state_e     state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [CW-1:0] scnt_q, scnt_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          gcnt_q, gcnt_d;
    logic [DW-1:0] top_q, top_d;
    logic [DW-1:0] btm_q, btm_d;
    logic          updn_q, updn_d;
    logic          pls_q, pls_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          tmo_err_q, tmo_err_d;
    logic          ovr_err_q, ovr_err_d;

    logic          enter;
    logic          upd;
    logic [CW-1:0] len_eff;
    logic          last_smp;
    logic          tmo_hit;
    logic [DW-1:0] max_nxt;
    logic [DW-1:0] min_nxt;

    assign upd      = (state_q == ACQ) && adc_vld;
    assign len_eff  = (len_q == '0) ? CW'(1) : len_q;
    assign last_smp = adc_vld && (scnt_q == (len_eff - CW'(1)));
    assign tmo_hit  = (tmo_q != '0) && (tcnt_q == (tmo_q - CW'(1)));

    pp_minmax #(.DW(DW)) u_minmax (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (enter),
        .upd_i     (upd),
        .dat_i     (adc_dat),
        .max_nxt_c (max_nxt),
        .min_nxt_c (min_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            tmo_q     <= '0;
            scnt_q    <= '0;
            tcnt_q    <= '0;
            pcnt_q    <= '0;
            gcnt_q    <= 1'b0;
            top_q     <= '0;
            btm_q     <= '0;
            updn_q    <= 1'b0;
            pls_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            tmo_q     <= tmo_d;
            scnt_q    <= scnt_d;
            tcnt_q    <= tcnt_d;
            pcnt_q    <= pcnt_d;
            gcnt_q    <= gcnt_d;
            top_q     <= top_d;
            btm_q     <= btm_d;
            updn_q    <= updn_d;
            pls_q     <= pls_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            tmo_err_q <= tmo_err_d;
            ovr_err_q <= ovr_err_d;
        end
    end

    // Results are latched on the ACQ exit edge so they are valid during the LATCH cycle.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        tmo_d     = tmo_q;
        scnt_d    = scnt_q;
        tcnt_d    = tcnt_q;
        pcnt_d    = pcnt_q;
        gcnt_d    = gcnt_q;
        top_d     = top_q;
        btm_d     = btm_q;
        updn_d    = updn_q;
        pls_d     = pls_q;
        done_d    = 1'b0;
        tmo_err_d = tmo_err_q;
        ovr_err_d = ovr_err_q;
        enter     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ACQ;
                    enter   = 1'b1;
                end
            end
            ACQ: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                    if (adc_vld) scnt_d = scnt_q + CW'(1);
                    if (last_smp) begin
                        state_d = LATCH;
                        top_d   = max_nxt;
                        btm_d   = min_nxt;
                        updn_d  = ~updn_q;
                        done_d  = 1'b1;
                    end else if (tmo_hit) begin
                        state_d   = LATCH;
                        top_d     = '0;
                        btm_d     = '0;
                        updn_d    = ~updn_q;
                        done_d    = 1'b1;
                        tmo_err_d = 1'b1;
                    end
                end
            end
            LATCH: begin
                state_d = STROBE;
                pls_d   = 1'b1;
                pcnt_d  = '0;
            end
            STROBE: begin
                if (pcnt_q == PW'(PLS_W - 1)) begin
                    state_d = GAP;
                    pls_d   = 1'b0;
                    gcnt_d  = 1'b0;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            GAP: begin
                if (gcnt_q) begin
                    if (en) begin
                        state_d = ACQ;
                        enter   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gcnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter) begin
            len_d  = rf_win_len;
            tmo_d  = rf_win_tmo;
            scnt_d = '0;
            tcnt_d = '0;
        end

        if (adc_vld && en && (state_q inside {LATCH, STROBE, GAP})) ovr_err_d = 1'b1;
    end

    assign busy_d    = (state_d != IDLE);

    assign rf_pp_top = top_q;
    assign rf_pp_btm = btm_q;
    assign rf_up_dn  = updn_q;
    assign pls       = pls_q;
    assign win_done  = done_q;
    assign busy      = busy_q;
    assign tmo_err   = tmo_err_q;
    assign ovr_err   = ovr_err_q;

endmodule

// File: tb/tb_pp_win_ctl.sv
// Directed bench for pp_win_ctl: windows, len=0, timeout, back-to-back, en abort and reset.
module tb_pp_win_ctl;

    localparam int unsigned DW = 12;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CW-1:0] rf_win_len;
    logic [CW-1:0] rf_win_tmo;
    logic          adc_vld;
    logic [DW-1:0] adc_dat;
    logic [DW-1:0] rf_pp_top;
    logic [DW-1:0] rf_pp_btm;
    logic          rf_up_dn;
    logic          pls;
    logic          win_done;
    logic          busy;
    logic          tmo_err;
    logic          ovr_err;

    int checks = 0;
    int errors = 0;

    pp_win_ctl #(.DW(DW), .CW(CW), .PLS_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rf_win_len (rf_win_len),
        .rf_win_tmo (rf_win_tmo),
        .adc_vld    (adc_vld),
        .adc_dat    (adc_dat),
        .rf_pp_top  (rf_pp_top),
        .rf_pp_btm  (rf_pp_btm),
        .rf_up_dn   (rf_up_dn),
        .pls        (pls),
        .win_done   (win_done),
        .busy       (busy),
        .tmo_err    (tmo_err),
        .ovr_err    (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [DW-1:0] d);
        adc_vld = 1'b1;
        adc_dat = d;
        tick();
        adc_vld = 1'b0;
    endtask

    task automatic count_pls(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (pls) n++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        skip(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rf_pp_top, rf_pp_btm, rf_up_dn, pls, win_done, busy, tmo_err, ovr_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got top=%0d btm=%0d updn=%b pls=%b done=%b busy=%b tmo=%b ovr=%b want all 0",
                     rf_pp_top, rf_pp_btm, rf_up_dn, pls, win_done, busy, tmo_err, ovr_err);
        end
    endtask

    task automatic test_basic();
        int n;
        rf_win_len = 16'd4; rf_win_tmo = 16'd0; en = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        send(12'd100); send(12'd3000); send(12'd50); send(12'd2047);
        checks++;
        if (rf_pp_top !== 12'd3000 || rf_pp_btm !== 12'd50) begin
            errors++; $display("FAIL basic_peaks got %0d/%0d want 3000/50", rf_pp_top, rf_pp_btm);
        end
        checks++;
        if (rf_up_dn !== 1'b1 || win_done !== 1'b1 || pls !== 1'b0) begin
            errors++; $display("FAIL basic_latch got updn=%b done=%b pls=%b want 1 1 0", rf_up_dn, win_done, pls);
        end
        tick();
        checks++;
        if (win_done !== 1'b0 || pls !== 1'b1) begin
            errors++; $display("FAIL basic_strobe_start got done=%b pls=%b want 0 1", win_done, pls);
        end
        count_pls(10, n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL basic_pls_width got %0d want 4", n); end
        en = 1'b0;
        skip(2);
    endtask

    task automatic test_len_zero();
        int n;
        rf_win_len = 16'd0; en = 1'b1;
        tick();
        send(12'd1234);
        checks++;
        if (rf_pp_top !== 12'd1234 || rf_pp_btm !== 12'd1234 || win_done !== 1'b1 || rf_up_dn !== 1'b0) begin
            errors++; $display("FAIL len0_latch got %0d/%0d done=%b updn=%b want 1234/1234 1 0",
                               rf_pp_top, rf_pp_btm, win_done, rf_up_dn);
        end
        tick();
        count_pls(10, n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL len0_pls got %0d want 4", n); end
        en = 1'b0;
        skip(2);
    endtask

    task automatic test_timeout();
        int n;
        rf_win_len = 16'd8; rf_win_tmo = 16'd20; en = 1'b1;
        tick();
        send(12'd900); send(12'd300); send(12'd600);
        skip(16);
        checks++;
        if (win_done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL tmo_early got done=%b busy=%b want 0 1", win_done, busy);
        end
        tick();
        checks++;
        if (win_done !== 1'b1 || rf_pp_top !== '0 || rf_pp_btm !== '0 || tmo_err !== 1'b1 || rf_up_dn !== 1'b1) begin
            errors++; $display("FAIL tmo_latch got done=%b %0d/%0d tmo=%b updn=%b want 1 0/0 1 1",
                               win_done, rf_pp_top, rf_pp_btm, tmo_err, rf_up_dn);
        end
        tick();
        count_pls(10, n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL tmo_pls got %0d want 4", n); end
        en = 1'b0;
        skip(2);
        // Completion on the timeout cycle must win.
        do_reset();
        rf_win_len = 16'd2; rf_win_tmo = 16'd5; en = 1'b1;
        tick();
        send(12'd500);
        skip(3);
        send(12'd600);
        checks++;
        if (win_done !== 1'b1 || rf_pp_top !== 12'd600 || rf_pp_btm !== 12'd500 || tmo_err !== 1'b0) begin
            errors++; $display("FAIL tmo_tie got done=%b %0d/%0d tmo=%b want 1 600/500 0",
                               win_done, rf_pp_top, rf_pp_btm, tmo_err);
        end
        en = 1'b0;
        skip(10);
    endtask

    task automatic test_back_to_back();
        do_reset();
        rf_win_len = 16'd2; rf_win_tmo = 16'd0; en = 1'b1;
        tick();
        send(12'd10); send(12'd20);
        checks++;
        if (rf_pp_top !== 12'd20 || rf_pp_btm !== 12'd10 || rf_up_dn !== 1'b1) begin
            errors++; $display("FAIL b2b_w1 got %0d/%0d updn=%b want 20/10 1", rf_pp_top, rf_pp_btm, rf_up_dn);
        end
        tick();
        send(12'd1);
        checks++;
        if (ovr_err !== 1'b1 || pls !== 1'b1) begin
            errors++; $display("FAIL b2b_ovr got ovr=%b pls=%b want 1 1", ovr_err, pls);
        end
        skip(5);
        send(12'd5); send(12'd4095);
        checks++;
        if (rf_pp_top !== 12'd4095 || rf_pp_btm !== 12'd5 || rf_up_dn !== 1'b0) begin
            errors++; $display("FAIL b2b_w2 got %0d/%0d updn=%b want 4095/5 0", rf_pp_top, rf_pp_btm, rf_up_dn);
        end
        skip(7);
        send(12'd7); send(12'd7);
        checks++;
        if (rf_pp_top !== 12'd7 || rf_pp_btm !== 12'd7 || rf_up_dn !== 1'b1 || win_done !== 1'b1) begin
            errors++; $display("FAIL b2b_w3 got %0d/%0d updn=%b done=%b want 7/7 1 1",
                               rf_pp_top, rf_pp_btm, rf_up_dn, win_done);
        end
        en = 1'b0;
        skip(10);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_en_drop();
        int n;
        rf_win_len = 16'd4; en = 1'b1;
        tick();
        send(12'd1);
        en = 1'b0;
        send(12'd2);
        checks++;
        if (busy !== 1'b0 || rf_pp_top !== 12'd7 || rf_pp_btm !== 12'd7 || rf_up_dn !== 1'b1) begin
            errors++; $display("FAIL abort_hold got busy=%b %0d/%0d updn=%b want 0 7/7 1",
                               busy, rf_pp_top, rf_pp_btm, rf_up_dn);
        end
        count_pls(10, n);
        checks++;
        if (n != 0 || win_done !== 1'b0) begin
            errors++; $display("FAIL abort_nopls got pls_cycles=%0d done=%b want 0 0", n, win_done);
        end
        rf_win_len = 16'd2; en = 1'b1;
        tick();
        send(12'd30); send(12'd40);
        tick();
        en = 1'b0;
        count_pls(10, n);
        checks++;
        if (n != 4 || busy !== 1'b0 || rf_pp_top !== 12'd40 || rf_pp_btm !== 12'd30) begin
            errors++; $display("FAIL strobe_en_drop got pls_cycles=%0d busy=%b %0d/%0d want 4 0 40/30",
                               n, busy, rf_pp_top, rf_pp_btm);
        end
    endtask

    task automatic test_rst_strobe();
        rf_win_len = 16'd2; en = 1'b1;
        tick();
        send(12'd1); send(12'd2);
        skip(2);
        checks++;
        if (pls !== 1'b1 || ovr_err !== 1'b1) begin
            errors++; $display("FAIL rst_pre got pls=%b ovr=%b want 1 1", pls, ovr_err);
        end
        rst = 1'b1;
        en  = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if ({rf_pp_top, rf_pp_btm, rf_up_dn, pls, win_done, busy, tmo_err, ovr_err} !== '0) begin
            errors++; $display("FAIL rst_strobe got top=%0d btm=%0d updn=%b pls=%b done=%b busy=%b tmo=%b ovr=%b want all 0",
                               rf_pp_top, rf_pp_btm, rf_up_dn, pls, win_done, busy, tmo_err, ovr_err);
        end
        skip(3);
        checks++;
        if (pls !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_idle got pls=%b busy=%b want 0 0", pls, busy);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; adc_vld = 1'b0; adc_dat = '0;
        rf_win_len = '0; rf_win_tmo = '0;
        test_reset();
        test_basic();
        test_len_zero();
        test_timeout();
        test_back_to_back();
        test_en_drop();
        test_rst_strobe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
